// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, bus widths
// and the access-error predicate.
package dmem_pkg;

   localparam int WORD_W = 32;
   localparam int STRB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Upper address bits are compared in full so out-of-range words never alias.
   function automatic logic calc_err(input logic [WORD_W-1:0] addr,
                                     input logic [WORD_W-1:0] depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the core (master) and the data-memory responder (slave).
interface dmem_if;
   import dmem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [WORD_W-1:0] req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic [STRB_W-1:0] req_wstrb;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WORD_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 storage split into byte lanes: synchronous byte-enabled write,
// synchronous registered read. No reset, contents survive reset_n.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [STRB_W-1:0]        be,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WORD_W-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WORD_W-1:0]        rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < STRB_W; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_q;

         always_ff @(posedge clk) begin
            if (we && be[gi]) begin
               mem[waddr] <= wdata[8*gi +: 8];
            end
            if (re) begin
               rd_q <= mem[raddr];
            end
         end

         assign rdata[8*gi +: 8] = rd_q;
      end
   endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: accepts one load/store, waits WAIT_STATES cycles, accesses
// the array once, then holds the response until the core takes it.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic   clk,
   input  logic   reset_n,
   dmem_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              write_q, write_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic              err_q, err_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rd_ok_q, rd_ok_d;

   logic              in_err;
   logic              acc_fire;
   logic              acc_write;
   logic [AW-1:0]     acc_idx;
   logic [WORD_W-1:0] acc_wdata;
   logic [STRB_W-1:0] acc_wstrb;
   logic              acc_err;
   logic [WORD_W-1:0] arr_rdata;

   assign in_err = calc_err(bus.req_addr, 32'(DEPTH));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rd_ok_d     = rd_ok_q;
      acc_fire    = 1'b0;
      acc_write   = write_q;
      acc_idx     = idx_q;
      acc_wdata   = wdata_q;
      acc_wstrb   = wstrb_q;
      acc_err     = err_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               write_d = bus.req_write;
               idx_d   = bus.req_addr[AW+1:2];
               wdata_d = bus.req_wdata;
               wstrb_d = bus.req_wstrb;
               err_d   = in_err;
               // With no wait states the array is accessed straight from the bus.
               if (WAIT_STATES == 0) begin
                  acc_fire  = 1'b1;
                  acc_write = bus.req_write;
                  acc_idx   = bus.req_addr[AW+1:2];
                  acc_wdata = bus.req_wdata;
                  acc_wstrb = bus.req_wstrb;
                  acc_err   = in_err;
                  state_d   = RESP;
               end else begin
                  cnt_d   = 4'(WAIT_STATES);
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               acc_fire = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rd_ok_d     = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (acc_fire) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = acc_err;
         rd_ok_d     = !acc_write && !acc_err;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_ok_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rd_ok_q     <= rd_ok_d;
      end
   end

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk   (clk),
      .we    (acc_fire && acc_write && !acc_err),
      .be    (acc_wstrb),
      .waddr (acc_idx),
      .wdata (acc_wdata),
      .re    (acc_fire && !acc_write && !acc_err),
      .raddr (acc_idx),
      .rdata (arr_rdata)
   );

   // The array read register only updates on a load, so it holds through RESP.
   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rd_ok_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dmem_if a_if ();
   dmem_if b_if ();

   dmem_responder #(.DEPTH(64), .WAIT_STATES(2)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (a_if)
   );

   dmem_responder #(.DEPTH(64), .WAIT_STATES(0)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b_if)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full transaction on the two-wait-state instance, checking latency and handshake.
   task automatic a_txn(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rdata, input logic exp_err);
      check({tag, ":req_ready"}, 32'(a_if.req_ready), 32'd1);
      a_if.req_valid = 1'b1;
      a_if.req_write = wr;
      a_if.req_addr  = addr;
      a_if.req_wdata = wdata;
      a_if.req_wstrb = strb;
      step();
      a_if.req_valid = 1'b0;
      a_if.req_addr  = 32'hFFFF_FFFF;
      a_if.req_wdata = 32'h5A5A_5A5A;
      a_if.req_wstrb = 4'hF;
      check({tag, ":valid_c1"}, 32'(a_if.rsp_valid), 32'd0);
      step();
      check({tag, ":valid_c2"}, 32'(a_if.rsp_valid), 32'd0);
      step();
      check({tag, ":valid_c3"}, 32'(a_if.rsp_valid), 32'd1);
      check({tag, ":rdata"}, a_if.rsp_rdata, exp_rdata);
      check({tag, ":err"}, 32'(a_if.rsp_err), 32'(exp_err));
      a_if.rsp_ready = 1'b1;
      step();
      a_if.rsp_ready = 1'b0;
      check({tag, ":valid_done"}, 32'(a_if.rsp_valid), 32'd0);
      check({tag, ":err_clr"}, 32'(a_if.rsp_err), 32'd0);
   endtask

   initial begin
      a_if.req_valid = 1'b0; a_if.req_write = 1'b0; a_if.req_addr = '0;
      a_if.req_wdata = '0;   a_if.req_wstrb = '0;   a_if.rsp_ready = 1'b0;
      b_if.req_valid = 1'b0; b_if.req_write = 1'b0; b_if.req_addr = '0;
      b_if.req_wdata = '0;   b_if.req_wstrb = '0;   b_if.rsp_ready = 1'b1;

      step();
      step();
      check("rst:req_ready", 32'(a_if.req_ready), 32'd1);
      check("rst:rsp_valid", 32'(a_if.rsp_valid), 32'd0);
      check("rst:rsp_rdata", a_if.rsp_rdata, 32'd0);
      check("rst:rsp_err", 32'(a_if.rsp_err), 32'd0);
      check("rst:b_valid", 32'(b_if.rsp_valid), 32'd0);
      reset_n = 1'b1;
      step();

      // Store and load back
      a_txn("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
      a_txn("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

      // Byte strobes
      a_txn("st20", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
      a_txn("st20s", 1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0);
      a_txn("ld20", 1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0);
      a_txn("st10z", 1'b1, 32'h10, 32'h0000_0000, 4'h0, 32'h0, 1'b0);
      a_txn("ld10z", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

      // Errors and range boundaries
      a_txn("st00", 1'b1, 32'h0, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
      a_txn("ld13", 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
      a_txn("st100", 1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
      a_txn("sthi", 1'b1, 32'h8000_0010, 32'h0, 4'hF, 32'h0, 1'b1);
      a_txn("ld00", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0102_0304, 1'b0);
      a_txn("ld10b", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
      a_txn("stFC", 1'b1, 32'hFC, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
      a_txn("ldFC", 1'b0, 32'hFC, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
      a_txn("ld100", 1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b1);
      a_txn("ld00b", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0102_0304, 1'b0);

      // Back-pressure on the response channel
      a_if.req_valid = 1'b1; a_if.req_write = 1'b0; a_if.req_addr = 32'h20;
      step();
      a_if.req_valid = 1'b0;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         check("bp:valid", 32'(a_if.rsp_valid), 32'd1);
         check("bp:rdata", a_if.rsp_rdata, 32'h11BB_33DD);
         check("bp:req_ready", 32'(a_if.req_ready), 32'd0);
         step();
      end
      check("bp:valid_hold", 32'(a_if.rsp_valid), 32'd1);
      a_if.rsp_ready = 1'b1;
      step();
      a_if.rsp_ready = 1'b0;
      check("bp:valid_done", 32'(a_if.rsp_valid), 32'd0);
      check("bp:req_ready_done", 32'(a_if.req_ready), 32'd1);

      // Zero wait states, rsp_ready tied high, req_valid held high
      b_if.req_valid = 1'b1; b_if.req_write = 1'b1; b_if.req_addr = 32'h4;
      b_if.req_wdata = 32'h1234_5678; b_if.req_wstrb = 4'hF;
      step();
      check("b:st4_valid", 32'(b_if.rsp_valid), 32'd1);
      check("b:st4_ready", 32'(b_if.req_ready), 32'd0);
      check("b:st4_rdata", b_if.rsp_rdata, 32'h0);
      b_if.req_addr = 32'h8; b_if.req_wdata = 32'h9ABC_DEF0;
      step();
      check("b:idle1_valid", 32'(b_if.rsp_valid), 32'd0);
      check("b:idle1_ready", 32'(b_if.req_ready), 32'd1);
      step();
      check("b:st8_valid", 32'(b_if.rsp_valid), 32'd1);
      b_if.req_write = 1'b0; b_if.req_addr = 32'h4;
      step();
      check("b:idle2_valid", 32'(b_if.rsp_valid), 32'd0);
      step();
      check("b:ld4_valid", 32'(b_if.rsp_valid), 32'd1);
      check("b:ld4_rdata", b_if.rsp_rdata, 32'h1234_5678);
      b_if.req_addr = 32'h8;
      step();
      check("b:idle3_ready", 32'(b_if.req_ready), 32'd1);
      step();
      check("b:ld8_valid", 32'(b_if.rsp_valid), 32'd1);
      check("b:ld8_rdata", b_if.rsp_rdata, 32'h9ABC_DEF0);
      b_if.req_valid = 1'b0;
      step();
      check("b:end_valid", 32'(b_if.rsp_valid), 32'd0);
      step();
      check("b:end_quiet", 32'(b_if.rsp_valid), 32'd0);

      // Reset during WAIT discards the pending store
      a_txn("st08", 1'b1, 32'h8, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0);
      a_if.req_valid = 1'b1; a_if.req_write = 1'b1; a_if.req_addr = 32'h8;
      a_if.req_wdata = 32'hCAFE_F00D; a_if.req_wstrb = 4'hF;
      step();
      a_if.req_valid = 1'b0;
      check("rw:in_wait", 32'(a_if.req_ready), 32'd0);
      step();
      reset_n = 1'b0;
      #1;
      check("rw:async_ready", 32'(a_if.req_ready), 32'd1);
      check("rw:async_valid", 32'(a_if.rsp_valid), 32'd0);
      step();
      step();
      reset_n = 1'b1;
      step();
      check("rw:post_valid", 32'(a_if.rsp_valid), 32'd0);
      check("rw:post_ready", 32'(a_if.req_ready), 32'd1);
      a_txn("ld08", 1'b0, 32'h8, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
